// File: rtl/mul_seq_ctrl.sv
// Moore sequencer for the shift-add multiplier. It steps the AH/AL accumulator through
// WIDTH conditional-add / right-shift iterations and pulses done when the product is ready.
module mul_seq_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic             abort,
    input  logic             al_lsb,
    output logic [1:0]       hs,
    output logic [1:0]       ls,
    output logic             ah_inen,
    output logic             ah_reset,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] bit_cnt
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_EVAL  = 3'd2,
        S_ADD   = 3'd3,
        S_SHIFT = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic [1:0]       MODE_HOLD  = 2'b00;
    localparam logic [1:0]       MODE_SHR   = 2'b01;
    localparam logic [1:0]       MODE_LOAD  = 2'b11;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       hs_q, ls_q;
    logic             ah_inen_q, ah_reset_q, busy_q, done_q;

    always_comb begin
        state_d = S_IDLE;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                state_d = S_EVAL;
                cnt_d   = '0;
            end
            S_EVAL:  state_d = al_lsb ? S_ADD : S_SHIFT;
            S_ADD:   state_d = S_SHIFT;
            S_SHIFT: begin
                // Terminal test precedes the increment, so the counter never wraps.
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_EVAL;
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            cnt_d   = cnt_q;
        end
    end

    // Outputs are registered from the next state so they track the registered state exactly.
    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            hs_q       <= MODE_HOLD;
            ls_q       <= MODE_HOLD;
            ah_inen_q  <= 1'b0;
            ah_reset_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hs_q       <= (state_d == S_ADD)   ? MODE_LOAD :
                          (state_d == S_SHIFT) ? MODE_SHR  : MODE_HOLD;
            ls_q       <= (state_d == S_LOAD)  ? MODE_LOAD :
                          (state_d == S_SHIFT) ? MODE_SHR  : MODE_HOLD;
            ah_inen_q  <= (state_d == S_ADD);
            ah_reset_q <= (state_d == S_LOAD);
            busy_q     <= (state_d != S_IDLE);
            done_q     <= (state_d == S_DONE);
        end
    end

    assign hs       = hs_q;
    assign ls       = ls_q;
    assign ah_inen  = ah_inen_q;
    assign ah_reset = ah_reset_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign bit_cnt  = cnt_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed bench for mul_seq_ctrl, with a small behavioural AH/AL accumulator so a
// full multiply can be checked end to end.
module tb_mul_seq_ctrl;

    logic       clk = 1'b0;
    logic       clr, start, abort, al_lsb;
    logic [1:0] hs, ls;
    logic       ah_inen, ah_reset, busy, done;
    logic [2:0] bit_cnt;

    logic       use_acc, force_lsb, done_seen;
    logic [3:0] mult_in, aludata;
    logic [3:0] ah_q, al_q;
    logic       c_q;
    int         compared, mismatched, cyc;

    always #5 clk = ~clk;

    mul_seq_ctrl #(.WIDTH(4), .CNT_W(3)) dut (
        .clk(clk), .clr(clr), .start(start), .abort(abort), .al_lsb(al_lsb),
        .hs(hs), .ls(ls), .ah_inen(ah_inen), .ah_reset(ah_reset),
        .busy(busy), .done(done), .bit_cnt(bit_cnt)
    );

    assign al_lsb = use_acc ? al_q[0] : force_lsb;

    // Accumulator: AH loads sum (carry kept) or shifts right taking the carry; AL loads or shifts in AH lsb.
    always @(posedge clk) begin
        if (ah_reset) begin
            ah_q <= 4'd0;
            c_q  <= 1'b0;
        end else if (hs == 2'b11) begin
            {c_q, ah_q} <= ah_inen ? ({1'b0, ah_q} + {1'b0, aludata}) : 5'd0;
        end else if (hs == 2'b01) begin
            ah_q <= {c_q, ah_q[3:1]};
            c_q  <= 1'b0;
        end
        if (ls == 2'b11)      al_q <= mult_in;
        else if (ls == 2'b01) al_q <= {ah_q[0], al_q[3:1]};
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        compared = 0; mismatched = 0; cyc = 0;
        clr = 1'b0; start = 1'b1; abort = 1'b0;
        use_acc = 1'b0; force_lsb = 1'b0; done_seen = 1'b0;
        mult_in = 4'd0; aludata = 4'd0;

        // T1: reset held with start asserted
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_hs", hs, 0);
        chk("rst_ls", ls, 0);
        chk("rst_ah_inen", ah_inen, 0);
        chk("rst_ah_reset", ah_reset, 0);
        chk("rst_done", done, 0);
        chk("rst_bit_cnt", bit_cnt, 0);
        clr = 1'b1;
        tick();
        chk("t1_load_busy", busy, 1);
        chk("t1_load_ah_reset", ah_reset, 1);
        chk("t1_load_ls", ls, 3);
        chk("t1_load_hs", hs, 0);
        start = 1'b0; abort = 1'b1;
        tick();
        chk("t1_abort_busy", busy, 0);
        abort = 1'b0;

        // Reset mid-run overrides a busy sequence
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick(); tick();
        chk("midrst_pre_cnt", bit_cnt, 1);
        clr = 1'b0; tick();
        chk("midrst_busy", busy, 0);
        chk("midrst_cnt", bit_cnt, 0);
        chk("midrst_hs", hs, 0);
        clr = 1'b1; tick();

        // T2: multiplier 0000
        force_lsb = 1'b0;
        start = 1'b1; tick(); start = 1'b0; cyc = 1;
        chk("t2_load_ls", ls, 3);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t2_eval_hs", hs, 0);
            chk("t2_eval_cnt", bit_cnt, i);
            tick();
            chk("t2_shift_hs", hs, 1);
            chk("t2_shift_ls", ls, 1);
            chk("t2_shift_cnt", bit_cnt, i);
        end
        tick();
        chk("t2_done", done, 1);
        chk("t2_done_cycle", cyc, 10);
        tick();
        chk("t2_after_done", done, 0);
        chk("t2_after_busy", busy, 0);

        // T3: multiplier 1111
        force_lsb = 1'b1;
        start = 1'b1; tick(); start = 1'b0; cyc = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t3_eval_hs", hs, 0);
            tick();
            chk("t3_add_hs", hs, 3);
            chk("t3_add_inen", ah_inen, 1);
            chk("t3_add_ls", ls, 0);
            tick();
            chk("t3_shift_hs", hs, 1);
            chk("t3_shift_cnt", bit_cnt, i);
        end
        tick();
        chk("t3_done", done, 1);
        chk("t3_done_cycle", cyc, 14);
        tick();

        // T4: 1011 x 0110 through the accumulator
        use_acc = 1'b1; mult_in = 4'b0110; aludata = 4'b1011;
        start = 1'b1; tick(); start = 1'b0; cyc = 1;
        while (!done && cyc < 40) tick();
        chk("t4_done_seen", done, 1);
        chk("t4_done_cycle", cyc, 12);
        chk("t4_product", {ah_q, al_q}, 8'h42);
        tick();
        use_acc = 1'b0;

        // T5: abort during the second ADD
        force_lsb = 1'b1; done_seen = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick(); tick(); tick(); tick();
        chk("t5_second_add", hs, 3);
        abort = 1'b1; tick(); abort = 1'b0;
        chk("t5_abort_busy", busy, 0);
        chk("t5_abort_hs", hs, 0);
        done_seen = done_seen | done;
        for (int i = 0; i < 12; i++) begin
            tick();
            done_seen = done_seen | done;
        end
        chk("t5_no_done", done_seen, 0);
        chk("t5_idle_busy", busy, 0);

        // T6: start ignored mid-run and in DONE; accepted in the following IDLE
        force_lsb = 1'b0;
        start = 1'b1; tick(); start = 1'b0; cyc = 1;
        tick(); tick(); tick();
        start = 1'b1; tick(); start = 1'b0;
        chk("t6_midstart_hs", hs, 1);
        chk("t6_midstart_noload", ah_reset, 0);
        repeat (5) tick();
        chk("t6_done", done, 1);
        chk("t6_done_cycle", cyc, 10);
        start = 1'b1; tick();
        chk("t6_done_start_ignored", busy, 0);
        tick();
        chk("t6_idle_start_load", ah_reset, 1);
        chk("t6_idle_start_busy", busy, 1);
        start = 1'b0; abort = 1'b1; tick(); abort = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
